insn_prefetch_queue: RTL and testbench

Instruction prefetch unit sitting directly downstream of the instruction cache: it generates sequential word fetches from the current CS:IP, consumes the cache's 16-bit acknowledged data, and buffers instruction bytes in a small byte FIFO for the decoder. It handles odd start addresses, 64 KiB segment wrap, and branch flushes, including flushes that arrive while a fetch is outstanding.

---
 rtl/insn_prefetch_queue.sv | 145 ++++++++++++++
 tb/tb_insn_prefetch_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_prefetch_queue.sv
// Instruction prefetch queue: sequential CS:IP word fetches buffered as bytes for the decoder.
// Optional PREFETCH_BYPASS_EN shows ack data combinationally while the queue is empty.
module insn_prefetch_queue #(
  parameter int DEPTH = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [19:1]                fetch_addr,
  output logic                       fetch_access,
  input  logic [15:0]                fetch_data,
  input  logic                       fetch_ack,
  input  logic                       load_new_ip,
  input  logic [15:0]                new_cs,
  input  logic [15:0]                new_ip,
  input  logic                       fifo_rd_en,
  output logic [7:0]                 fifo_data,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t        state;
  logic [15:0]   cs;
  logic [15:0]   fetch_ip;
  logic [7:0]    ring [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [19:0] phys_of(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'b0} + {4'b0, off};
  endfunction

  logic        odd;
  logic        push;
  logic        pop;
  logic        space;
  logic [1:0]  push_n;
  logic [7:0]  first_byte;
  logic [15:0] cs_nxt;
  logic [15:0] ip_nxt;
  logic [19:0] nxt_phys;
  logic [LW:0] level_nxt;

  // The segment shifted by 4 never touches bit 0, so byte parity is the offset's.
  assign odd        = fetch_ip[0];
  assign push       = (state == FETCH) && fetch_ack && !load_new_ip;
  assign push_n     = push ? (odd ? 2'd1 : 2'd2) : 2'd0;
  assign first_byte = odd ? fetch_data[15:8] : fetch_data[7:0];

`ifdef PREFETCH_BYPASS_EN
  assign fifo_empty = (level == '0) && !push;
  assign fifo_data  = ((level == '0) && push) ? first_byte : ring[rd_ptr];
`else
  assign fifo_empty = (level == '0);
  assign fifo_data  = ring[rd_ptr];
`endif

  assign pop        = fifo_rd_en && !fifo_empty && !load_new_ip;
  assign fifo_level = level;
  assign level_nxt  = load_new_ip ? '0
                    : (LW+1)'(level) + (LW+1)'(push_n) - (LW+1)'(pop);

  always_comb begin
    cs_nxt = cs;
    ip_nxt = fetch_ip;
    if (load_new_ip) begin
      cs_nxt = new_cs;
      ip_nxt = new_ip;
    end else if (push) begin
      ip_nxt = fetch_ip + (odd ? 16'd1 : 16'd2);
    end
  end

  assign nxt_phys = phys_of(cs_nxt, ip_nxt);
  assign space    = level_nxt <= (LW+1)'(nxt_phys[0] ? DEPTH - 1 : DEPTH - 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      fetch_access <= 1'b0;
      cs           <= 16'hFFFF;
      fetch_ip     <= '0;
      fetch_addr   <= 19'h7FFF8;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      level        <= '0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else begin
      cs       <= cs_nxt;
      fetch_ip <= ip_nxt;
      level    <= level_nxt[LW-1:0];
      // An outstanding request keeps its address until acked, even across a flush.
      if (state == IDLE || fetch_ack) fetch_addr <= nxt_phys[19:1];

      if (load_new_ip) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        if (push) begin
          ring[wr_ptr] <= first_byte;
          if (odd) begin
            wr_ptr <= ptr_inc(wr_ptr);
          end else begin
            ring[ptr_inc(wr_ptr)] <= fetch_data[15:8];
            wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
          end
        end
      end

      case (state)
        IDLE: begin
          state        <= space ? FETCH : IDLE;
          fetch_access <= space;
        end
        FETCH: begin
          if (fetch_ack) begin
            state        <= (space && !load_new_ip) ? FETCH : IDLE;
            fetch_access <= space && !load_new_ip;
          end else if (load_new_ip) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (fetch_ack) begin
            state        <= IDLE;
            fetch_access <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          fetch_access <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_insn_prefetch_queue.sv
// Bench for insn_prefetch_queue: directed scenarios plus randomized traffic against a byte-queue model.
module tb_insn_prefetch_queue;
  localparam int DEPTH = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:1] fetch_addr;
  logic        fetch_access;
  logic [15:0] fetch_data = '0;
  logic        fetch_ack = 1'b0;
  logic        load_new_ip = 1'b0;
  logic [15:0] new_cs = '0;
  logic [15:0] new_ip = '0;
  logic        fifo_rd_en = 1'b0;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic [2:0]  fifo_level;

  int errs = 0;
  int checks = 0;

  insn_prefetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fetch_access(fetch_access),
    .fetch_data(fetch_data), .fetch_ack(fetch_ack), .load_new_ip(load_new_ip),
    .new_cs(new_cs), .new_ip(new_ip), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task step();
    @(posedge clk);
    #1;
  endtask

  task ack_word(input logic [15:0] d);
    fetch_ack = 1'b1;
    fetch_data = d;
    step();
    fetch_ack = 1'b0;
  endtask

  task pop_byte();
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
  endtask

  task load_ip(input logic [15:0] c, input logic [15:0] i);
    load_new_ip = 1'b1;
    new_cs = c;
    new_ip = i;
    step();
    load_new_ip = 1'b0;
  endtask

  task restart(input logic [15:0] c, input logic [15:0] i);
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_ip(c, i);
  endtask

  task test_reset();
    step();
    step();
    checks++; if (fetch_access !== 1'b0) begin errs++; $display("FAIL rst_access got %b want 0", fetch_access); end
    checks++; if (fetch_addr !== 19'h7FFF8) begin errs++; $display("FAIL rst_addr got %h want 7fff8", fetch_addr); end
    checks++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL rst_empty got %b want 1", fifo_empty); end
    checks++; if (fifo_level !== 3'd0) begin errs++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    checks++; if (fifo_data !== 8'h00) begin errs++; $display("FAIL rst_data got %h want 00", fifo_data); end
    reset = 1'b0;
    #1;
    checks++; if (fetch_access !== 1'b0) begin errs++; $display("FAIL rel_access_early got %b want 0", fetch_access); end
    step();
    checks++; if (fetch_access !== 1'b1) begin errs++; $display("FAIL rel_access got %b want 1", fetch_access); end
    checks++; if (fetch_addr !== 19'h7FFF8) begin errs++; $display("FAIL rel_addr got %h want 7fff8", fetch_addr); end
    ack_word(16'h00EA);
    checks++; if (fifo_level !== 3'd2) begin errs++; $display("FAIL rst_ack_level got %0d want 2", fifo_level); end
    checks++; if (fifo_data !== 8'hEA) begin errs++; $display("FAIL rst_ack_data0 got %h want ea", fifo_data); end
    checks++; if (fetch_addr !== 19'h7FFF9) begin errs++; $display("FAIL rst_next_addr got %h want 7fff9", fetch_addr); end
    pop_byte();
    checks++; if (fifo_data !== 8'h00) begin errs++; $display("FAIL rst_ack_data1 got %h want 00", fifo_data); end
    pop_byte();
    checks++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL rst_drained got %b want 1", fifo_empty); end
    // asynchronous reset while a request is outstanding
    reset = 1'b1;
    #1;
    checks++; if (fetch_access !== 1'b0) begin errs++; $display("FAIL async_rst_access got %b want 0", fetch_access); end
  endtask

  task test_even();
    restart(16'h1000, 16'h0000);
    checks++; if (fetch_addr !== 19'h08000) begin errs++; $display("FAIL even_addr got %h want 08000", fetch_addr); end
    checks++; if (fetch_access !== 1'b1) begin errs++; $display("FAIL even_access got %b want 1", fetch_access); end
    ack_word(16'h3412);
    checks++; if (fifo_data !== 8'h12) begin errs++; $display("FAIL even_b0 got %h want 12", fifo_data); end
    checks++; if (fetch_addr !== 19'h08001) begin errs++; $display("FAIL even_next got %h want 08001", fetch_addr); end
    pop_byte();
    checks++; if (fifo_data !== 8'h34) begin errs++; $display("FAIL even_b1 got %h want 34", fifo_data); end
    pop_byte();
    checks++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL even_empty got %b want 1", fifo_empty); end
  endtask

  task test_odd();
    restart(16'h1000, 16'h0001);
    checks++; if (fetch_addr !== 19'h08000) begin errs++; $display("FAIL odd_addr got %h want 08000", fetch_addr); end
    ack_word(16'hAABB);
    checks++; if (fifo_level !== 3'd1) begin errs++; $display("FAIL odd_level got %0d want 1", fifo_level); end
    checks++; if (fifo_data !== 8'hAA) begin errs++; $display("FAIL odd_data got %h want aa", fifo_data); end
    checks++; if (fetch_addr !== 19'h08001) begin errs++; $display("FAIL odd_next got %h want 08001", fetch_addr); end
  endtask

  task test_full();
    restart(16'h1000, 16'h0000);
    ack_word(16'h2211);
    ack_word(16'h4433);
    ack_word(16'h6655);
    checks++; if (fifo_level !== 3'd6) begin errs++; $display("FAIL full_level got %0d want 6", fifo_level); end
    checks++; if (fetch_access !== 1'b0) begin errs++; $display("FAIL full_access got %b want 0", fetch_access); end
    checks++; if (fifo_data !== 8'h11) begin errs++; $display("FAIL full_head got %h want 11", fifo_data); end
    pop_byte();
    step();
    step();
    checks++; if (fifo_level !== 3'd5) begin errs++; $display("FAIL full_pop1_level got %0d want 5", fifo_level); end
    checks++; if (fetch_access !== 1'b0) begin errs++; $display("FAIL full_pop1_access got %b want 0", fetch_access); end
    checks++; if (fifo_data !== 8'h22) begin errs++; $display("FAIL full_pop1_data got %h want 22", fifo_data); end
    pop_byte();
    checks++; if (fetch_access !== 1'b1) begin errs++; $display("FAIL full_pop2_access got %b want 1", fetch_access); end
    checks++; if (fetch_addr !== 19'h08003) begin errs++; $display("FAIL full_pop2_addr got %h want 08003", fetch_addr); end
    checks++; if (fifo_data !== 8'h33) begin errs++; $display("FAIL full_pop2_data got %h want 33", fifo_data); end
  endtask

  task test_empty_pop();
    restart(16'h0400, 16'h0010);
    pop_byte();
    checks++; if (fifo_level !== 3'd0) begin errs++; $display("FAIL empty_pop_level got %0d want 0", fifo_level); end
    ack_word(16'h5544);
    checks++; if (fifo_data !== 8'h44) begin errs++; $display("FAIL empty_pop_data got %h want 44", fifo_data); end
    fifo_rd_en = 1'b1;
    load_new_ip = 1'b1;
    new_cs = 16'h0500;
    new_ip = 16'h0000;
    step();
    fifo_rd_en = 1'b0;
    load_new_ip = 1'b0;
    checks++; if (fifo_level !== 3'd0) begin errs++; $display("FAIL flush_wins_level got %0d want 0", fifo_level); end
    checks++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL flush_wins_empty got %b want 1", fifo_empty); end
  endtask

  task test_discard();
    restart(16'h1000, 16'h0000);
    load_ip(16'h2000, 16'h0100);
    step();
    step();
    checks++; if (fetch_access !== 1'b1) begin errs++; $display("FAIL disc_access got %b want 1", fetch_access); end
    checks++; if (fetch_addr !== 19'h08000) begin errs++; $display("FAIL disc_hold_addr got %h want 08000", fetch_addr); end
    ack_word(16'hBEEF);
    checks++; if (fifo_level !== 3'd0) begin errs++; $display("FAIL disc_level got %0d want 0", fifo_level); end
    checks++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL disc_empty got %b want 1", fifo_empty); end
    step();
    checks++; if (fetch_access !== 1'b1) begin errs++; $display("FAIL disc_resume got %b want 1", fetch_access); end
    checks++; if (fetch_addr !== 19'h10080) begin errs++; $display("FAIL disc_new_addr got %h want 10080", fetch_addr); end
    ack_word(16'h5678);
    checks++; if (fifo_data !== 8'h78) begin errs++; $display("FAIL disc_data got %h want 78", fifo_data); end
  endtask

  task test_ack_with_load();
    restart(16'h1000, 16'h0000);
    fetch_ack = 1'b1;
    fetch_data = 16'h1234;
    load_new_ip = 1'b1;
    new_cs = 16'h3000;
    new_ip = 16'h0000;
    step();
    fetch_ack = 1'b0;
    load_new_ip = 1'b0;
    checks++; if (fifo_level !== 3'd0) begin errs++; $display("FAIL ackload_level got %0d want 0", fifo_level); end
    step();
    checks++; if (fetch_access !== 1'b1) begin errs++; $display("FAIL ackload_access got %b want 1", fetch_access); end
    checks++; if (fetch_addr !== 19'h18000) begin errs++; $display("FAIL ackload_addr got %h want 18000", fetch_addr); end
  endtask

  task test_wrap();
    restart(16'h2000, 16'hFFFE);
    checks++; if (fetch_addr !== 19'h17FFF) begin errs++; $display("FAIL wrap_addr got %h want 17fff", fetch_addr); end
    ack_word(16'h0201);
    checks++; if (fetch_addr !== 19'h10000) begin errs++; $display("FAIL wrap_next got %h want 10000", fetch_addr); end
    checks++; if (fifo_data !== 8'h01) begin errs++; $display("FAIL wrap_data got %h want 01", fifo_data); end
  endtask

  task test_random();
    logic [7:0]  q[$];
    logic [15:0] m_cs;
    logic [15:0] m_ip;
    logic [19:0] ph;
    logic [19:1] disc_addr;
    logic [19:1] exp_addr;
    logic [7:0]  exp_data;
    bit discard, acc, ack, rd, ld, push, exp_empty, pop_ok;
    int pushed;
    pushed = 0;
    discard = 1'b0;
    disc_addr = '0;
    m_cs = 16'($urandom);
    m_ip = 16'($urandom);
    restart(m_cs, m_ip);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = fetch_access;
      ack = acc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      rd = ((c / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ld = ($urandom_range(0, 80) == 0);
      fetch_ack = ack;
      fetch_data = 16'($urandom);
      fifo_rd_en = rd;
      load_new_ip = ld;
      if (ld) begin
        new_cs = 16'($urandom);
        new_ip = 16'($urandom);
      end
      #1;
      ph = {m_cs, 4'b0} + {4'b0, m_ip};
      exp_addr = discard ? disc_addr : ph[19:1];
      push = acc && ack && !ld && !discard;
      if (acc) begin
        checks++; if (fetch_addr !== exp_addr) begin errs++; $display("FAIL rnd_addr cyc %0d got %h want %h", c, fetch_addr, exp_addr); end
      end
`ifdef PREFETCH_BYPASS_EN
      exp_empty = (q.size() == 0) && !push;
`else
      exp_empty = (q.size() == 0);
`endif
      checks++; if (fifo_empty !== exp_empty) begin errs++; $display("FAIL rnd_empty cyc %0d got %b want %b", c, fifo_empty, exp_empty); end
      if (!exp_empty) begin
        exp_data = (q.size() > 0) ? q[0] : (ph[0] ? fetch_data[15:8] : fetch_data[7:0]);
        checks++; if (fifo_data !== exp_data) begin errs++; $display("FAIL rnd_data cyc %0d got %h want %h", c, fifo_data, exp_data); end
      end
      checks++; if (int'(fifo_level) !== q.size()) begin errs++; $display("FAIL rnd_level cyc %0d got %0d want %0d", c, fifo_level, q.size()); end
      pop_ok = rd && !exp_empty && !ld;
      if (ld) begin
        if (acc && !ack) begin
          if (!discard) disc_addr = ph[19:1];
          discard = 1'b1;
        end else begin
          discard = 1'b0;
        end
        q.delete();
        m_cs = new_cs;
        m_ip = new_ip;
      end else if (acc && ack) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          if (!ph[0]) q.push_back(fetch_data[7:0]);
          q.push_back(fetch_data[15:8]);
          pushed += ph[0] ? 1 : 2;
          m_ip = m_ip + (ph[0] ? 16'd1 : 16'd2);
        end
      end
      if (pop_ok) void'(q.pop_front());
      if (push) begin
        checks++; if (q.size() > DEPTH) begin errs++; $display("FAIL rnd_overflow cyc %0d got %0d want <=%0d", c, q.size(), DEPTH); end
      end
    end
    fetch_ack = 1'b0;
    fifo_rd_en = 1'b0;
    load_new_ip = 1'b0;
    checks++; if (pushed < 200) begin errs++; $display("FAIL rnd_progress got %0d bytes want >=200", pushed); end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_full();
    test_empty_pop();
    test_discard();
    test_ack_with_load();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
